// File: rtl/nova_io_initiator.sv
// rtl/nova_io_initiator.sv - Nova I/O bus initiator: sequences NIO/DIx/DOx/SKP strobe cycles
// Nova numbers bits MSB-first; Nova bit i lives at vector index 15-i (7-i on bs_adr).
module nova_io_initiator #(
    parameter int BUSY_BIT = 0,
    parameter int DONE_BIT = 1
) (
    input  logic        pclk,
    input  logic        prst_n,
    input  logic        io_req,
    input  logic [15:0] io_insn,
    input  logic [15:0] io_acin,
    output logic        io_done,
    output logic [1:0]  io_acsel,
    output logic        io_acwe,
    output logic [15:0] io_acout,
    output logic        io_skip,
    output logic        bs_stb,
    output logic        bs_we,
    output logic [7:0]  bs_adr,
    output logic [15:0] bs_din,
    input  logic [15:0] bs_dout
);

    typedef enum logic [2:0] {
        IDLE, XFER, RDW, SKRD, SKW, CTRL, DONE
    } state_t;

    state_t     state;
    logic [1:0] ctl_q;
    logic [5:0] dev_q;
    logic       di_q;

    logic       req_is_io;
    logic [2:0] req_op;
    logic [1:0] req_ctl;
    logic [5:0] req_dev;
    logic [1:0] req_sub;
    logic       flag_busy;
    logic       flag_done;
    logic       skip_dec;

    assign req_is_io = (io_insn[15:13] == 3'b011);
    assign req_op    = io_insn[10:8];
    assign req_ctl   = io_insn[7:6];
    assign req_dev   = io_insn[5:0];
    assign flag_busy = bs_dout[15 - BUSY_BIT];
    assign flag_done = bs_dout[15 - DONE_BIT];

    // Sub-register select for data transfers: A=01, B=10, C=11.
    always_comb begin
        req_sub = 2'b00;
        case (req_op)
            3'b001, 3'b010: req_sub = 2'b01;
            3'b011, 3'b100: req_sub = 2'b10;
            3'b101, 3'b110: req_sub = 2'b11;
            default:        req_sub = 2'b00;
        endcase
    end

    // Skip condition selected by the ctl field of a SKP.
    always_comb begin
        skip_dec = 1'b0;
        case (ctl_q)
            2'b00:   skip_dec = flag_busy;
            2'b01:   skip_dec = !flag_busy;
            2'b10:   skip_dec = flag_done;
            default: skip_dec = !flag_done;
        endcase
    end

    // Sequencer; every output is registered on entry to the state that owns it.
    always_ff @(posedge pclk) begin
        if (!prst_n) begin
            state    <= IDLE;
            ctl_q    <= 2'b00;
            dev_q    <= 6'd0;
            di_q     <= 1'b0;
            io_done  <= 1'b0;
            io_acsel <= 2'b00;
            io_acwe  <= 1'b0;
            io_acout <= 16'd0;
            io_skip  <= 1'b0;
            bs_stb   <= 1'b0;
            bs_we    <= 1'b0;
            bs_adr   <= 8'd0;
            bs_din   <= 16'd0;
        end else begin
            io_done <= 1'b0;
            io_acwe <= 1'b0;
            io_skip <= 1'b0;
            bs_stb  <= 1'b0;
            bs_we   <= 1'b0;
            bs_adr  <= 8'd0;
            bs_din  <= 16'd0;
            case (state)
                IDLE: begin
                    if (io_req) begin
                        io_acsel <= io_insn[12:11];
                        ctl_q    <= req_ctl;
                        dev_q    <= req_dev;
                        di_q     <= req_is_io && req_op[0] && (req_op != 3'b111);
                        if (!req_is_io) begin
                            state   <= DONE;
                            io_done <= 1'b1;
                        end else if (req_op == 3'b111) begin
                            state  <= SKRD;
                            bs_stb <= 1'b1;
                            bs_adr <= {req_dev, 2'b00};
                        end else if (req_op == 3'b000) begin
                            if (req_ctl != 2'b00) begin
                                state  <= CTRL;
                                bs_stb <= 1'b1;
                                bs_we  <= 1'b1;
                                bs_adr <= {req_dev, 2'b00};
                                bs_din <= {14'd0, req_ctl};
                            end else begin
                                state   <= DONE;
                                io_done <= 1'b1;
                            end
                        end else begin
                            state  <= XFER;
                            bs_stb <= 1'b1;
                            bs_we  <= !req_op[0];
                            bs_adr <= {req_dev, req_sub};
                            bs_din <= req_op[0] ? 16'd0 : io_acin;
                        end
                    end
                end
                XFER: begin
                    if (di_q) begin
                        state <= RDW;
                    end else if (ctl_q != 2'b00) begin
                        state  <= CTRL;
                        bs_stb <= 1'b1;
                        bs_we  <= 1'b1;
                        bs_adr <= {dev_q, 2'b00};
                        bs_din <= {14'd0, ctl_q};
                    end else begin
                        state   <= DONE;
                        io_done <= 1'b1;
                    end
                end
                RDW: begin
                    io_acout <= bs_dout;
                    if (ctl_q != 2'b00) begin
                        state  <= CTRL;
                        bs_stb <= 1'b1;
                        bs_we  <= 1'b1;
                        bs_adr <= {dev_q, 2'b00};
                        bs_din <= {14'd0, ctl_q};
                    end else begin
                        state   <= DONE;
                        io_done <= 1'b1;
                        io_acwe <= 1'b1;
                    end
                end
                SKRD: state <= SKW;
                SKW: begin
                    io_acout <= bs_dout;
                    io_skip  <= skip_dec;
                    io_done  <= 1'b1;
                    state    <= DONE;
                end
                CTRL: begin
                    state   <= DONE;
                    io_done <= 1'b1;
                    io_acwe <= di_q;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nova_io_initiator.sv
// tb/tb_nova_io_initiator.sv - self-checking bench for nova_io_initiator
module tb_nova_io_initiator;

    localparam int BUSY_BIT = 0;
    localparam int DONE_BIT = 1;

    logic        pclk = 1'b0;
    logic        prst_n;
    logic        io_req;
    logic [15:0] io_insn;
    logic [15:0] io_acin;
    logic        io_done;
    logic [1:0]  io_acsel;
    logic        io_acwe;
    logic [15:0] io_acout;
    logic        io_skip;
    logic        bs_stb;
    logic        bs_we;
    logic [7:0]  bs_adr;
    logic [15:0] bs_din;
    logic [15:0] bs_dout = 16'd0;
    logic        bs_rst = 1'b0;
    logic [15:0] resp_data = 16'd0;
    int          rst_count = 0;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    nova_io_initiator #(.BUSY_BIT(BUSY_BIT), .DONE_BIT(DONE_BIT)) dut (
        .pclk(pclk), .prst_n(prst_n), .io_req(io_req), .io_insn(io_insn),
        .io_acin(io_acin), .io_done(io_done), .io_acsel(io_acsel),
        .io_acwe(io_acwe), .io_acout(io_acout), .io_skip(io_skip),
        .bs_stb(bs_stb), .bs_we(bs_we), .bs_adr(bs_adr), .bs_din(bs_din),
        .bs_dout(bs_dout)
    );

    // Responder: registered read data; DIC 77 raises bs_rst for one cycle.
    always @(posedge pclk) begin
        bs_rst <= 1'b0;
        if (bs_stb && !bs_we) begin
            bs_dout <= resp_data;
            if (bs_adr == 8'o377) begin
                bs_rst    <= 1'b1;
                rst_count <= rst_count + 1;
            end
        end
    end

    typedef struct packed {
        logic        stb;
        logic        we;
        logic [7:0]  adr;
        logic [15:0] din;
        logic        done;
        logic        acwe;
        logic        skip;
    } cyc_t;

    typedef struct {
        logic [15:0] insn;
        logic [15:0] acin;
        logic [15:0] resp;
        int          cyc;
        logic        skip;
        logic        acwe;
    } vec_t;

    cyc_t        exp_q[$];
    logic [15:0] exp_acout = 16'd0;
    vec_t        vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] mk_insn(input logic [1:0] ac, input logic [2:0] op,
                                            input logic [1:0] ctl, input logic [5:0] dev);
        return {3'b011, ac, op, ctl, dev};
    endfunction

    function automatic cyc_t mk_cyc(input logic stb, input logic we, input logic [7:0] adr,
                                    input logic [15:0] din, input logic done,
                                    input logic acwe, input logic skip);
        cyc_t c;
        c.stb = stb; c.we = we; c.adr = adr; c.din = din;
        c.done = done; c.acwe = acwe; c.skip = skip;
        return c;
    endfunction

    // Reference: list of expected cycles after the accept edge, from the instruction rules.
    task automatic build(input logic [15:0] insn, input logic [15:0] acin, input logic [15:0] resp);
        int          op;
        int          ctl;
        logic [5:0]  dev;
        logic [1:0]  sub;
        logic        busy;
        logic        dn;
        logic        sk;
        logic        rd;
        op   = int'(insn[10:8]);
        ctl  = int'(insn[7:6]);
        dev  = insn[5:0];
        busy = resp[15 - BUSY_BIT];
        dn   = resp[15 - DONE_BIT];
        exp_q.delete();
        if (insn[15:13] != 3'b011) begin
            exp_q.push_back(mk_cyc(0, 0, 0, 0, 1, 0, 0));
        end else if (op == 7) begin
            sk = (ctl == 0) ? busy : (ctl == 1) ? !busy : (ctl == 2) ? dn : !dn;
            exp_q.push_back(mk_cyc(1, 0, {dev, 2'b00}, 0, 0, 0, 0));
            exp_q.push_back(mk_cyc(0, 0, 0, 0, 0, 0, 0));
            exp_q.push_back(mk_cyc(0, 0, 0, 0, 1, 0, sk));
            exp_acout = resp;
        end else begin
            rd = (op % 2) == 1;
            if (op != 0) begin
                sub = 2'((op + 1) / 2);
                if (rd) begin
                    exp_q.push_back(mk_cyc(1, 0, {dev, sub}, 0, 0, 0, 0));
                    exp_q.push_back(mk_cyc(0, 0, 0, 0, 0, 0, 0));
                    exp_acout = resp;
                end else begin
                    exp_q.push_back(mk_cyc(1, 1, {dev, sub}, acin, 0, 0, 0));
                end
            end
            if (ctl != 0)
                exp_q.push_back(mk_cyc(1, 1, {dev, 2'b00}, 16'(ctl), 0, 0, 0));
            exp_q.push_back(mk_cyc(0, 0, 0, 0, 1, rd, 0));
        end
    endtask

    task automatic run_insn(input logic [15:0] insn, input logic [15:0] acin, input logic [15:0] resp,
                            output int done_cyc, output logic skip_at, output logic acwe_at);
        cyc_t act;
        build(insn, acin, resp);
        @(negedge pclk);
        resp_data = resp;
        io_insn   = insn;
        io_acin   = acin;
        io_req    = 1'b1;
        @(posedge pclk);
        #1;
        io_req  = 1'b0;
        io_insn = 16'($urandom);
        io_acin = 16'($urandom);
        done_cyc = -1;
        skip_at  = 1'b0;
        acwe_at  = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge pclk);
            act = mk_cyc(bs_stb, bs_we, bs_adr, bs_din, io_done, io_acwe, io_skip);
            chk($sformatf("cyc%0d_insn%04h", k + 1, insn), act, exp_q[k]);
            if (io_done && done_cyc < 0) begin
                done_cyc = k + 1;
                skip_at  = io_skip;
                acwe_at  = io_acwe;
            end
        end
        chk($sformatf("acout_insn%04h", insn), io_acout, exp_acout);
        chk($sformatf("acsel_insn%04h", insn), io_acsel, insn[12:11]);
    endtask

    function automatic logic [63:0] all_outs();
        return {io_done, io_acsel, io_acwe, io_acout, io_skip, bs_stb, bs_we, bs_adr, bs_din};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          dc;
        logic        sk;
        logic        aw;
        int          rst_before;
        logic [15:0] ri;

        vecs[0]  = '{mk_insn(2'd1, 3'o2, 2'd0, 6'o77), 16'h1234, 16'h0000, 2, 1'b0, 1'b0};
        vecs[1]  = '{mk_insn(2'd2, 3'o1, 2'd1, 6'o77), 16'h0000, 16'h8010, 4, 1'b0, 1'b1};
        vecs[2]  = '{mk_insn(2'd0, 3'o7, 2'd2, 6'o21), 16'h0000, 16'h4000, 3, 1'b1, 1'b0};
        vecs[3]  = '{mk_insn(2'd0, 3'o7, 2'd3, 6'o21), 16'h0000, 16'h4000, 3, 1'b0, 1'b0};
        vecs[4]  = '{mk_insn(2'd0, 3'o7, 2'd0, 6'o21), 16'h0000, 16'h8000, 3, 1'b1, 1'b0};
        vecs[5]  = '{mk_insn(2'd0, 3'o7, 2'd1, 6'o21), 16'h0000, 16'h8000, 3, 1'b0, 1'b0};
        vecs[6]  = '{mk_insn(2'd3, 3'o2, 2'd3, 6'o12), 16'hbeef, 16'h0000, 3, 1'b0, 1'b0};
        vecs[7]  = '{mk_insn(2'd1, 3'o0, 2'd2, 6'o12), 16'h0000, 16'h0000, 2, 1'b0, 1'b0};
        vecs[8]  = '{mk_insn(2'd1, 3'o0, 2'd0, 6'o12), 16'h0000, 16'h0000, 1, 1'b0, 1'b0};
        vecs[9]  = '{16'h0000, 16'h0000, 16'h0000, 1, 1'b0, 1'b0};
        vecs[10] = '{mk_insn(2'd2, 3'o4, 2'd0, 6'o55), 16'h0f0f, 16'h0000, 2, 1'b0, 1'b0};
        vecs[11] = '{mk_insn(2'd0, 3'o5, 2'd0, 6'o77), 16'h0000, 16'habcd, 3, 1'b0, 1'b1};

        // Reset held two cycles with a request pending.
        prst_n  = 1'b0;
        io_req  = 1'b1;
        io_insn = mk_insn(2'd1, 3'o2, 2'd0, 6'o77);
        io_acin = 16'hffff;
        repeat (2) @(posedge pclk);
        #1;
        chk("reset_outputs", all_outs(), 64'd0);
        @(negedge pclk);
        chk("reset_no_strobe", bs_stb, 1'b0);
        prst_n = 1'b1;
        io_req = 1'b0;

        // Table-driven instructions.
        foreach (vecs[i]) begin
            rst_before = rst_count;
            run_insn(vecs[i].insn, vecs[i].acin, vecs[i].resp, dc, sk, aw);
            chk($sformatf("v%0d_done_cycle", i), 64'(dc), 64'(vecs[i].cyc));
            chk($sformatf("v%0d_skip", i), sk, vecs[i].skip);
            chk($sformatf("v%0d_acwe", i), aw, vecs[i].acwe);
            if (i == 11)
                chk("iorst_bs_rst_seen", rst_count - rst_before, 1);
        end

        // io_req pulse during XFER is ignored.
        @(negedge pclk);
        io_insn = mk_insn(2'd0, 3'o2, 2'd0, 6'o33);
        io_acin = 16'h5555;
        io_req  = 1'b1;
        @(posedge pclk);
        #1;
        io_req = 1'b0;
        @(negedge pclk);
        chk("xfer_busy_strobe", {bs_stb, bs_we, bs_adr}, {2'b11, 6'o33, 2'b01});
        io_insn = mk_insn(2'd0, 3'o1, 2'd0, 6'o44);
        io_req  = 1'b1;
        @(posedge pclk);
        #1;
        io_req = 1'b0;
        @(negedge pclk);
        chk("xfer_busy_done", {io_done, bs_stb}, 2'b10);
        @(negedge pclk);
        chk("xfer_busy_no_queue1", {io_done, bs_stb}, 2'b00);
        @(negedge pclk);
        chk("xfer_busy_no_queue2", {io_done, bs_stb}, 2'b00);

        // Reset during RDW aborts with no io_done and clears every output.
        @(negedge pclk);
        resp_data = 16'h7777;
        io_insn   = mk_insn(2'd3, 3'o1, 2'd0, 6'o12);
        io_req    = 1'b1;
        @(posedge pclk);
        #1;
        io_req = 1'b0;
        @(negedge pclk);
        chk("rdw_reset_strobe", {bs_stb, bs_we}, 2'b10);
        @(negedge pclk);
        prst_n = 1'b0;
        @(negedge pclk);
        chk("rdw_reset_outputs", all_outs(), 64'd0);
        prst_n    = 1'b1;
        exp_acout = 16'd0;
        @(negedge pclk);
        chk("rdw_reset_idle", all_outs(), 64'd0);
        @(negedge pclk);
        chk("rdw_reset_no_done", io_done, 1'b0);

        // io_req held high re-triggers in the IDLE cycle after DONE.
        @(negedge pclk);
        io_insn = mk_insn(2'd0, 3'o0, 2'd0, 6'o10);
        io_req  = 1'b1;
        @(posedge pclk);
        #1;
        @(negedge pclk);
        chk("retrig_done1", io_done, 1'b1);
        @(negedge pclk);
        chk("retrig_idle", io_done, 1'b0);
        @(negedge pclk);
        chk("retrig_done2", io_done, 1'b1);
        io_req = 1'b0;
        @(negedge pclk);
        chk("retrig_stop", io_done, 1'b0);

        // Randomized instructions against the reference.
        for (int n = 0; n < 60; n++) begin
            ri = 16'($urandom);
            if ($urandom_range(0, 3) != 0)
                ri[15:13] = 3'b011;
            run_insn(ri, 16'($urandom), 16'($urandom), dc, sk, aw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nova_io_initiator.md
# nova_io_initiator

Bus-initiator end of the Nova I/O bus: executes one decoded Nova I/O instruction (NIO/DIx/DOx/SKP) handed over by the CPU execute unit and turns it into strobe cycles on the device bus (`bs_stb`/`bs_we`/`bs_adr`/`bs_din`, read data on `bs_dout`). Every device responder, including the CPU pseudo-device 077, sits on the far end of this bus. The block returns load data, skip decisions and a one-cycle completion pulse to the execute unit.

## Interface
- `BUSY_BIT`, 0: bit index of the busy flag in the flag-read word.
- `DONE_BIT`, 1: bit index of the done flag in the flag-read word.

- `pclk`  in  1  clock; all logic on the rising edge.
- `prst_n`  in  1  reset, synchronous, active-low.
- `io_req`  in  1  start request; sampled only in IDLE.
- `io_insn`  in  16 [0:15]  I/O instruction: [0:2] = 011, [3:4] AC, [5:7] op, [8:9] ctl, [10:15] device.
- `io_acin`  in  16 [0:15]  accumulator value for DOx.
- `io_done`  out  1  one-cycle completion pulse.
- `io_acsel`  out  2  AC field latched from `io_insn[3:4]`.
- `io_acwe`  out  1  accumulator write strobe, high with `io_done` for DIx only.
- `io_acout`  out  16 [0:15]  captured read data.
- `io_skip`  out  1  skip decision, valid with `io_done` for SKP; 0 otherwise.
- `bs_stb`  out  1  bus strobe.
- `bs_we`  out  1  1 = write to device, 0 = read.
- `bs_adr`  out  8 [0:7]  [0:5] device, [6:7] sub-register.
- `bs_din`  out  16 [0:15]  write data to device.
- `bs_dout`  in  16 [0:15]  read data from device, registered by the responder.

## Operation
- Op decode on [5:7]:
  - 000 NIO: no transfer.
  - DIA 001, DIB 011, DIC 101: read sub 01/10/11.
  - DOA 010, DOB 100, DOC 110: write sub 01/10/11, `bs_din` = latched `io_acin`.
  - 111 SKP.
- Control phase:
  - Runs when ctl != 00 and op != SKP.
  - Write strobe to `{dev, 2'b00}` with `bs_din` = `{14'b0, ctl}` (01 start, 10 clear, 11 pulse).
  - Follows the data phase.
- SKP: read strobe to `{dev, 2'b00}`, capture the flag word, then decide:
  - ctl 00 BN: skip = busy.
  - ctl 01 BZ: skip = !busy.
  - ctl 10 DN: skip = done.
  - ctl 11 DZ: skip = !done.
- `io_insn[0:2]` != 011: complete as a no-op (no bus cycle, `io_done` only).
- State machine:
  - IDLE: on `io_req` latch insn and acin, then go to XFER (DIx/DOx), SKRD (SKP), CTRL (NIO, ctl != 00) or DONE (NIO with ctl 00, or non-I/O).
  - XFER: one-cycle strobe. Write goes to CTRL or DONE; read goes to RDW.
  - RDW: strobe low; capture `bs_dout` into `io_acout` at the end of the cycle; then CTRL or DONE.
  - SKRD: one-cycle read strobe → SKW.
  - SKW: capture the flags and compute skip → DONE.
  - CTRL: one-cycle write strobe → DONE.
  - DONE: `io_done`=1 (plus `io_acwe`, `io_skip` as applicable) → IDLE.
- Outside strobe cycles, `bs_stb`/`bs_we`/`bs_adr`/`bs_din` are driven 0, never z.
- `bs_rst` is not monitored. An IORST issued through this block (DIC 77) completes normally.

## Timing
- Reset (`prst_n`=0 at an edge): state IDLE; every output 0, including `io_acout` and `io_acsel`. Reset mid-sequence aborts the sequence at that edge, with no `io_done`.
- Accept edge = E0. Cycle n is the cycle after edge En-1.
- DOx, no ctl: strobe in cycle 1, `io_done` in cycle 2.
- DIx, no ctl: strobe in cycle 1, capture at E2, `io_done` + `io_acwe` in cycle 3.
- DOx + ctl: data strobe in cycle 1, control strobe in cycle 2, done in cycle 3.
- DIx + ctl: strobe in 1, capture at E2, control strobe in 3, done in 4. `io_acout` stays stable from E2.
- SKP: strobe in 1, capture at E2, done in 3.
- NIO + ctl: control strobe in 1, done in 2.
- NIO 00 / non-I/O: done in cycle 1.
- `io_req` outside IDLE is ignored and not queued. `io_req` held high re-triggers in the IDLE cycle after DONE.
- `io_acout` holds its last captured value until the next DIx or SKP capture. `io_skip` is 0 except in the SKP DONE cycle.

## Test plan
- Reset: hold `prst_n`=0 for 2 cycles with `io_req`=1 → all outputs 0, no strobe.
- DOA AC1, dev 077, `io_acin`=16'h1234, ctl 00:
  - cycle 1: `bs_stb`=1, `bs_we`=1, `bs_adr`=8'o375 (077<<2|01), `bs_din`=16'h1234.
  - cycle 2: `io_done`=1, `io_acwe`=0.
- DIA dev 077 + S, responder returns 16'h8010:
  - cycle 1: read strobe at 8'o375.
  - cycle 3: control strobe `bs_adr`=8'o374, `bs_din`=16'h0001.
  - cycle 4: `io_done`=1, `io_acwe`=1, `io_acout`=16'h8010, `io_acsel`=AC field.
- SKPDN with flag word 16'h4000 → skip=1 in cycle 3. SKPDZ with the same word → skip=0. SKPBN with 16'h8000 → skip=1.
- DIC dev 077 (IORST): responder raises `bs_rst` → sequence still completes, with `io_done` in cycle 3.
- Robustness:
  - `io_req` pulse during XFER → ignored.
  - `prst_n`=0 in RDW → IDLE, no `io_done`, outputs 0.
  - non-I/O insn 16'h0000 → `io_done` in cycle 1, no strobe.
